// File: rtl/mac_array_ctrl.sv
// Tile sequencer for the 4x4 weight-stationary systolic MAC array.
// Loads four weight words, streams input vectors and tracks array latency to strobe result writes.
module mac_array_ctrl #(
    parameter int unsigned ARRAY_LAT = 8,
    parameter int unsigned IDX_W     = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       cfg_n_cols,
    input  logic [IDX_W-1:0] cfg_n_vec,
    input  logic             cfg_accum,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [31:0]      w_data,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [31:0]      x_data,
    output logic             en_x_i,
    output logic [3:0]       en_w_i,
    output logic             stop_mac,
    output logic             used_row,
    output logic             overwrite_sig,
    output logic [31:0]      x_i,
    output logic [31:0]      w_i,
    output logic             psum_rd_en,
    output logic [IDX_W-1:0] psum_rd_addr,
    output logic             res_valid,
    output logic [IDX_W-1:0] res_addr,
    output logic             busy,
    output logic             done
);

    localparam int unsigned COLS   = 4;
    localparam int unsigned WCNT_W = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WLOAD  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [COLS-1:0]     r_mask;
    logic [IDX_W-1:0]    r_n_vec;
    logic                r_accum;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [IDX_W-1:0]    r_idx;
    logic [ARRAY_LAT-1:0] r_pipe_v;
    logic [IDX_W-1:0]    r_pipe_idx [ARRAY_LAT];

    logic                w_start_acc;
    logic                w_w_acc;
    logic                w_x_acc;
    logic [IDX_W-1:0]    w_idx_last;
    logic                w_pipe_busy;
    logic [COLS-1:0]     w_cfg_mask;
    logic [COLS-1:0]     w_en_w_nxt;
    logic                w_en_x_nxt;
    logic                w_stop_nxt;
    logic                w_accum_nxt;
    logic                w_busy_nxt;
    logic                w_used_nxt;
    logic                w_done_nxt;

    assign w_start_acc = start && (r_state == S_IDLE) && !abort;
    assign w_w_acc     = w_valid && w_ready && (r_state == S_WLOAD) && !abort;
    assign w_x_acc     = x_valid && x_ready && (r_state == S_STREAM) && !abort;
    assign w_idx_last  = IDX_W'(r_n_vec - IDX_W'(1));
    // The head stage is the result strobe itself, so it does not hold DRAIN open.
    assign w_pipe_busy = en_x_i || (|r_pipe_v[ARRAY_LAT-2:0]);

    assign res_valid = r_pipe_v[ARRAY_LAT-1];
    assign res_addr  = r_pipe_idx[ARRAY_LAT-1];

    // Column enable mask; 0 and out-of-range counts select all columns.
    always_comb begin
        w_cfg_mask = 4'b1111;
        case (cfg_n_cols)
            3'd1:    w_cfg_mask = 4'b1000;
            3'd2:    w_cfg_mask = 4'b1100;
            3'd3:    w_cfg_mask = 4'b1110;
            default: w_cfg_mask = 4'b1111;
        endcase
    end

    // Next state and next values of the registered strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_en_w_nxt  = w_w_acc ? r_mask : '0;
        w_en_x_nxt  = w_x_acc;
        w_stop_nxt  = 1'b0;
        w_accum_nxt = r_accum;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc) begin
                    w_state_nxt = S_WLOAD;
                    w_accum_nxt = cfg_accum;
                end
            end
            S_WLOAD: begin
                if (w_w_acc && (r_wcnt == WCNT_W'(3))) begin
                    w_state_nxt = (r_n_vec == '0) ? S_DRAIN : S_STREAM;
                end
            end
            S_STREAM: begin
                w_stop_nxt = !w_x_acc;
                if (w_x_acc && (r_idx == w_idx_last)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_stop_nxt = 1'b1;
                if (!w_pipe_busy) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_en_w_nxt  = '0;
            w_en_x_nxt  = 1'b0;
            w_stop_nxt  = 1'b0;
        end
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_used_nxt = (w_state_nxt == S_WLOAD) || (w_state_nxt == S_STREAM) ||
                     (w_state_nxt == S_DRAIN);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state       <= S_IDLE;
            r_mask        <= '0;
            r_n_vec       <= '0;
            r_accum       <= 1'b0;
            r_wcnt        <= '0;
            r_idx         <= '0;
            w_ready       <= 1'b0;
            x_ready       <= 1'b0;
            en_w_i        <= '0;
            w_i           <= '0;
            en_x_i        <= 1'b0;
            x_i           <= '0;
            stop_mac      <= 1'b0;
            psum_rd_en    <= 1'b0;
            psum_rd_addr  <= '0;
            busy          <= 1'b0;
            used_row      <= 1'b0;
            overwrite_sig <= 1'b0;
            done          <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_accum       <= w_accum_nxt;
            w_ready       <= (w_state_nxt == S_WLOAD);
            x_ready       <= (w_state_nxt == S_STREAM);
            busy          <= w_busy_nxt;
            used_row      <= w_used_nxt;
            overwrite_sig <= w_busy_nxt && w_accum_nxt;
            done          <= w_done_nxt;
            en_w_i        <= w_en_w_nxt;
            en_x_i        <= w_en_x_nxt;
            stop_mac      <= w_stop_nxt;
            psum_rd_en    <= w_en_x_nxt && r_accum;
            if (w_start_acc) begin
                r_mask  <= w_cfg_mask;
                r_n_vec <= cfg_n_vec;
                r_wcnt  <= '0;
                r_idx   <= '0;
            end
            if (w_w_acc) begin
                w_i    <= w_data;
                r_wcnt <= r_wcnt + WCNT_W'(1);
            end
            // Vector index saturates at the last vector of the tile.
            if (w_x_acc) begin
                x_i          <= x_data;
                psum_rd_addr <= r_idx;
                if (r_idx != w_idx_last) begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    // Latency tag pipeline: one {valid, index} entry per cycle, head drives the result strobe.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_pipe_v <= '0;
            for (int unsigned i = 0; i < ARRAY_LAT; i++) begin
                r_pipe_idx[i] <= '0;
            end
        end else if (abort) begin
            r_pipe_v <= '0;
            for (int unsigned i = 0; i < ARRAY_LAT; i++) begin
                r_pipe_idx[i] <= '0;
            end
        end else begin
            r_pipe_v      <= {r_pipe_v[ARRAY_LAT-2:0], en_x_i};
            r_pipe_idx[0] <= psum_rd_addr;
            for (int unsigned i = 1; i < ARRAY_LAT; i++) begin
                r_pipe_idx[i] <= r_pipe_idx[i-1];
            end
        end
    end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: table of tile configurations plus abort sequence,
// with queues of expected weight loads and result strobes checked every cycle.
`timescale 1ns/1ps
module tb_mac_array_ctrl;

    localparam int unsigned LAT = 8;
    localparam int unsigned IW  = 16;

    logic          CLK;
    logic          RSTN;
    logic          start;
    logic          abort;
    logic [2:0]    cfg_n_cols;
    logic [IW-1:0] cfg_n_vec;
    logic          cfg_accum;
    logic          w_valid;
    logic          w_ready;
    logic [31:0]   w_data;
    logic          x_valid;
    logic          x_ready;
    logic [31:0]   x_data;
    logic          en_x_i;
    logic [3:0]    en_w_i;
    logic          stop_mac;
    logic          used_row;
    logic          overwrite_sig;
    logic [31:0]   x_i;
    logic [31:0]   w_i;
    logic          psum_rd_en;
    logic [IW-1:0] psum_rd_addr;
    logic          res_valid;
    logic [IW-1:0] res_addr;
    logic          busy;
    logic          done;

    mac_array_ctrl #(.ARRAY_LAT(LAT), .IDX_W(IW)) dut (
        .CLK(CLK), .RSTN(RSTN), .start(start), .abort(abort),
        .cfg_n_cols(cfg_n_cols), .cfg_n_vec(cfg_n_vec), .cfg_accum(cfg_accum),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .en_x_i(en_x_i), .en_w_i(en_w_i), .stop_mac(stop_mac), .used_row(used_row),
        .overwrite_sig(overwrite_sig), .x_i(x_i), .w_i(w_i),
        .psum_rd_en(psum_rd_en), .psum_rd_addr(psum_rd_addr),
        .res_valid(res_valid), .res_addr(res_addr), .busy(busy), .done(done)
    );

    typedef struct { int cyc; logic [3:0] mask; logic [31:0] data; } wexp_t;
    typedef struct { int cyc; logic [IW-1:0] addr; } rexp_t;
    typedef struct {
        logic [2:0]    n_cols;
        logic [IW-1:0] n_vec;
        logic          accum;
        logic [7:0]    pat;
        int            pat_len;
        logic          start_mid;
        logic [3:0]    exp_mask;
        int            exp_res;
    } vec_t;

    wexp_t wq[$];
    rexp_t rq[$];
    vec_t  tbl [0:7];

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   exp_done_cyc = -1;
    int   res_seen = 0;
    logic cur_accum = 1'b0;
    logic mon_en = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle scoreboard of weight loads, result strobes, done and overwrite_sig.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                chk("en_w_i", 64'(en_w_i), 64'(wq[0].mask));
                chk("w_i", 64'(w_i), 64'(wq[0].data));
                wq.delete(0);
            end else begin
                chk("en_w_i_quiet", 64'(en_w_i), 64'(0));
            end
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                chk("res_valid", 64'(res_valid), 64'(1));
                chk("res_addr", 64'(res_addr), 64'(rq[0].addr));
                rq.delete(0);
            end else begin
                chk("res_valid_quiet", 64'(res_valid), 64'(0));
            end
            if (res_valid) res_seen++;
            chk("done", 64'(done), 64'(cyc == exp_done_cyc));
            chk("overwrite_sig", 64'(overwrite_sig), 64'(busy && cur_accum));
        end
    end

    task automatic do_start(input vec_t v);
        @(posedge CLK); #1;
        start        = 1'b1;
        cfg_n_cols   = v.n_cols;
        cfg_n_vec    = v.n_vec;
        cfg_accum    = v.accum;
        cur_accum    = v.accum;
        res_seen     = 0;
        exp_done_cyc = -1;
        @(posedge CLK); #1;
        start      = 1'b0;
        cfg_n_cols = 3'd1;
        cfg_n_vec  = 16'h00ff;
        cfg_accum  = ~v.accum;
    endtask

    task automatic load_weights(input logic [3:0] mask, output int last_w);
        int    widx;
        wexp_t we;
        widx    = 0;
        last_w  = -1;
        w_valid = 1'b1;
        w_data  = 32'h01020304;
        for (int b = 0; b < 20 && widx < 4; b++) begin
            @(negedge CLK);
            if (b == 0) begin
                chk("w_ready_rise", 64'(w_ready), 64'(1));
                chk("busy_rise", 64'(busy), 64'(1));
                chk("used_row_rise", 64'(used_row), 64'(1));
            end
            if (w_ready && w_valid) begin
                we.cyc  = cyc + 1;
                we.mask = mask;
                we.data = w_data;
                wq.push_back(we);
                last_w = cyc + 1;
                widx++;
            end
            @(posedge CLK); #1;
            if (widx < 4) w_data = 32'h01020304 + 32'(widx) * 32'h04040404;
            else          w_valid = 1'b0;
        end
        w_valid = 1'b0;
        if (widx != 4) chk("weight_accepts", 64'(widx), 64'(4));
    endtask

    task automatic stream(input vec_t v, output int last_res);
        int          k;
        int          it;
        int          prev;
        logic [31:0] pdata;
        int          pk;
        rexp_t       re;
        k = 0; it = 0; prev = 0; pdata = '0; pk = 0; last_res = -1;
        while ((k < int'(v.n_vec) || prev != 0) && it < 200) begin
            x_valid = (k < int'(v.n_vec)) ? v.pat[it % v.pat_len] : 1'b0;
            x_data  = $urandom;
            if (v.start_mid) begin
                start      = (it == 1);
                cfg_n_vec  = 16'd9;
                cfg_n_cols = 3'd3;
            end
            @(negedge CLK);
            if (it == 0) chk("x_ready_rise", 64'(x_ready), 64'(1));
            if (prev == 2) begin
                chk("en_x_i", 64'(en_x_i), 64'(1));
                chk("x_i", 64'(x_i), 64'(pdata));
                chk("stop_mac_run", 64'(stop_mac), 64'(0));
                chk("psum_rd_en", 64'(psum_rd_en), 64'(v.accum));
                chk("psum_rd_addr", 64'(psum_rd_addr), 64'(pk));
            end else if (prev == 1) begin
                chk("en_x_i_bubble", 64'(en_x_i), 64'(0));
                chk("stop_mac_bubble", 64'(stop_mac), 64'(1));
                chk("psum_rd_en_bubble", 64'(psum_rd_en), 64'(0));
                if (k > 0) chk("x_i_hold", 64'(x_i), 64'(pdata));
            end
            if (x_ready && x_valid) begin
                prev    = 2;
                pdata   = x_data;
                pk      = k;
                re.cyc  = cyc + 1 + int'(LAT);
                re.addr = IW'(k);
                rq.push_back(re);
                last_res = re.cyc;
                k++;
            end else if (x_ready) begin
                prev = 1;
            end else begin
                prev = 0;
            end
            @(posedge CLK); #1;
            it++;
        end
        x_valid = 1'b0;
        start   = 1'b0;
        if (k != int'(v.n_vec)) chk("x_accepts", 64'(k), 64'(v.n_vec));
    endtask

    task automatic run_tile(input vec_t v);
        int last_w;
        int last_res;
        do_start(v);
        load_weights(v.exp_mask, last_w);
        if (v.n_vec != '0) begin
            stream(v, last_res);
            exp_done_cyc = last_res + 1;
        end else begin
            exp_done_cyc = last_w + 1;
        end
        for (int b = 0; b < 40 && cyc <= exp_done_cyc; b++) @(negedge CLK);
        chk("busy_after_done", 64'(busy), 64'(0));
        chk("used_row_after_done", 64'(used_row), 64'(0));
        chk("res_count", 64'(res_seen), 64'(v.exp_res));
    endtask

    task automatic abort_seq();
        vec_t  a;
        int    last_w;
        int    k;
        rexp_t re;
        a = '{n_cols: 3'd4, n_vec: 16'd5, accum: 1'b1, pat: 8'h01, pat_len: 1,
              start_mid: 1'b0, exp_mask: 4'b1111, exp_res: 0};
        do_start(a);
        load_weights(a.exp_mask, last_w);
        k = 0;
        x_valid = 1'b1;
        for (int b = 0; b < 10 && k < 2; b++) begin
            x_data = $urandom;
            @(negedge CLK);
            if (x_ready && x_valid) begin
                re.cyc  = cyc + 1 + int'(LAT);
                re.addr = IW'(k);
                rq.push_back(re);
                k++;
            end
            @(posedge CLK); #1;
        end
        abort      = 1'b1;
        start      = 1'b1;
        x_valid    = 1'b0;
        cfg_n_vec  = 16'd3;
        @(negedge CLK);
        while (rq.size() > 0 && rq[rq.size()-1].cyc > cyc) void'(rq.pop_back());
        @(posedge CLK); #1;
        abort = 1'b0;
        start = 1'b0;
        @(negedge CLK);
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_en_x_i", 64'(en_x_i), 64'(0));
        chk("abort_stop_mac", 64'(stop_mac), 64'(0));
        chk("abort_x_ready", 64'(x_ready), 64'(0));
        chk("abort_start_ignored", 64'(w_ready), 64'(0));
        chk("abort_psum_rd_en", 64'(psum_rd_en), 64'(0));
        repeat (15) @(negedge CLK);
        chk("abort_no_results", 64'(res_seen), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{3'd4, 16'd3, 1'b0, 8'h01, 1, 1'b0, 4'b1111, 3};
        tbl[1] = '{3'd2, 16'd3, 1'b0, 8'h01, 1, 1'b0, 4'b1100, 3};
        tbl[2] = '{3'd4, 16'd3, 1'b0, 8'h19, 5, 1'b0, 4'b1111, 3};
        tbl[3] = '{3'd3, 16'd2, 1'b1, 8'h01, 1, 1'b0, 4'b1110, 2};
        tbl[4] = '{3'd4, 16'd0, 1'b0, 8'h01, 1, 1'b0, 4'b1111, 0};
        tbl[5] = '{3'd0, 16'd2, 1'b0, 8'h01, 1, 1'b0, 4'b1111, 2};
        tbl[6] = '{3'd1, 16'd4, 1'b1, 8'h03, 3, 1'b1, 4'b1000, 4};
        tbl[7] = '{3'd5, 16'd1, 1'b0, 8'h01, 1, 1'b0, 4'b1111, 1};

        RSTN = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_n_cols = '0; cfg_n_vec = '0; cfg_accum = 1'b0;
        w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0;
        repeat (3) @(negedge CLK);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_en_w_i", 64'(en_w_i), 64'(0));
        chk("rst_en_x_i", 64'(en_x_i), 64'(0));
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_ready", 64'({w_ready, x_ready}), 64'(0));
        chk("rst_flags", 64'({stop_mac, used_row, overwrite_sig, psum_rd_en}), 64'(0));
        chk("rst_data", 64'({x_i, w_i}), 64'(0));
        @(posedge CLK); #1;
        RSTN   = 1'b1;
        mon_en = 1'b1;

        for (int t = 0; t < 8; t++) run_tile(tbl[t]);
        abort_seq();
        run_tile(tbl[0]);

        repeat (3) @(negedge CLK);
        chk("queues_drained", 64'(wq.size() + rq.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
